ptp_ts_queue: RTL and testbench

Single-clock, parametrised first-word-fall-through timestamp queue for the TSU, successor to the fixed 128-bit x 16 dual-clock timestamp queue.

- Buffers captured PTP timestamp records between the capture logic and the host/register read-out path, both in one clock domain.
- Adds configurable width and depth, a selectable overflow policy (drop-newest or overwrite-oldest), a full-range occupancy count, an almost-full flag, a saturating drop counter and a synchronous flush.

---
 rtl/ptp_ts_queue.sv | 90 +++++++++
 tb/tb_ptp_ts_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ptp_ts_queue.sv
// rtl/ptp_ts_queue.sv - single-clock show-ahead timestamp queue with overflow policy and drop counter
module ptp_ts_queue #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 4,
  parameter int OVERWRITE   = 0,
  parameter int AFULL_LEVEL = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  rdempty,
  output logic                  wrfull,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic [15:0]           drop_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;

  logic full;
  logic empty;
  logic rd_ok;
  logic wr_ok;
  logic over_wr;
  logic drop;

  // Status decodes only from the count register so full and empty stay unambiguous.
  assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (count == '0);

  assign rd_ok   = rdreq & ~empty;
  assign wr_ok   = wrreq & (~full | rd_ok);
  assign drop    = ~flush & wrreq & full & ~rdreq;
  assign over_wr = drop & (OVERWRITE != 0);

  always_ff @(posedge clk) begin
    if (~flush & (wr_ok | over_wr)) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok | over_wr) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_ok | over_wr) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (wr_ok & ~rd_ok) begin
        count <= count + (ADDR_WIDTH+1)'(1);
      end else if (rd_ok & ~wr_ok) begin
        count <= count - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Survives flush so lost records stay visible to the host until a hard reset.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign q           = mem[rd_ptr];
  assign rdempty     = empty;
  assign wrfull      = full;
  assign almost_full = (int'(count) >= AFULL_LEVEL);
  assign usedw       = count;

endmodule

// File: tb/tb_ptp_ts_queue.sv
// tb/tb_ptp_ts_queue.sv - randomized and directed checks of ptp_ts_queue against a queue-based model
module tb_ptp_ts_queue;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;

  typedef logic [DW-1:0] dq_t[$];

  logic          clk;
  logic          aclr;
  logic          flush;
  logic [DW-1:0] data;
  logic          wrreq;
  logic          rdreq;

  logic [DW-1:0] q0, q1;
  logic          rdempty0, rdempty1, wrfull0, wrfull1, af0, af1;
  logic [AW:0]   usedw0, usedw1;
  logic [15:0]   dc0, dc1;

  int checks = 0;
  int errors = 0;

  dq_t m0, m1;
  int  md0 = 0, md1 = 0;

  ptp_ts_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OVERWRITE(0), .AFULL_LEVEL(AFL)) u_drop (
    .clk(clk), .aclr(aclr), .flush(flush), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q0), .rdempty(rdempty0), .wrfull(wrfull0), .almost_full(af0), .usedw(usedw0), .drop_cnt(dc0)
  );

  ptp_ts_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OVERWRITE(1), .AFULL_LEVEL(AFL)) u_ovw (
    .clk(clk), .aclr(aclr), .flush(flush), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q1), .rdempty(rdempty1), .wrfull(wrfull1), .almost_full(af1), .usedw(usedw1), .drop_cnt(dc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue semantics straight from the overflow rules; no pointers involved.
  task automatic model_step(inout dq_t m, inout int dc, input bit ow,
                            input bit w, input bit r, input bit f, input logic [DW-1:0] d);
    if (f) begin
      m.delete();
    end else if (w && !r && m.size() == DEPTH) begin
      if (dc < 16'hFFFF) dc++;
      if (ow) begin
        void'(m.pop_front());
        m.push_back(d);
      end
    end else begin
      if (r && m.size() > 0) void'(m.pop_front());
      if (w) m.push_back(d);
    end
  endtask

  task automatic compare(input string pfx, input dq_t m, input int dc, input logic [DW-1:0] qv,
                         input logic e, input logic fu, input logic a, input logic [AW:0] u,
                         input logic [15:0] d);
    check({pfx, "_usedw"}, 64'(u), 64'(m.size()));
    check({pfx, "_rdempty"}, 64'(e), 64'(m.size() == 0));
    check({pfx, "_wrfull"}, 64'(fu), 64'(m.size() == DEPTH));
    check({pfx, "_afull"}, 64'(a), 64'(m.size() >= AFL));
    check({pfx, "_drop_cnt"}, 64'(d), 64'(dc));
    if (m.size() > 0) check({pfx, "_q"}, 64'(qv), 64'(m[0]));
  endtask

  task automatic compare_all();
    compare("drop", m0, md0, q0, rdempty0, wrfull0, af0, usedw0, dc0);
    compare("ovw", m1, md1, q1, rdempty1, wrfull1, af1, usedw1, dc1);
  endtask

  // Inputs change just after the negedge; outputs sampled at the next negedge.
  task automatic step(input bit w, input bit r, input bit f, input logic [DW-1:0] d);
    wrreq = w; rdreq = r; flush = f; data = d;
    @(posedge clk);
    model_step(m0, md0, 1'b0, w, r, f, d);
    model_step(m1, md1, 1'b1, w, r, f, d);
    @(negedge clk);
    compare_all();
    wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0;
  endtask

  initial begin
    aclr = 1'b1; flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    check("reset_rdempty", 64'(rdempty0), 64'd1);
    check("reset_usedw", 64'(usedw0), 64'd0);
    check("reset_wrfull", 64'(wrfull1), 64'd0);
    aclr = 1'b0;

    // basic order
    for (int i = 1; i <= 3; i++) step(1, 0, 0, DW'(i));
    check("basic_head", 64'(q0), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
    check("basic_empty", 64'(rdempty0), 64'd1);

    // fill past full
    for (int i = 0; i < 18; i++) step(1, 0, 0, DW'(i));
    check("fill_drop_cnt", 64'(dc0), 64'd2);
    check("ovw_drop_cnt", 64'(dc1), 64'd2);
    check("ovw_usedw", 64'(usedw1), 64'd16);
    check("ovw_head", 64'(q1), 64'd2);
    check("drop_head", 64'(q0), 64'd0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, '0);

    // full queue, simultaneous read and write
    step(0, 0, 1, '0);
    md0 = 0; md1 = 0;
    aclr = 1'b1; #1; aclr = 1'b0;
    check("aclr_pulse_dc", 64'(dc0), 64'd0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, DW'(100 + i));
    for (int i = 0; i < 20; i++) step(1, 1, 0, DW'(200 + i));
    check("full_rw_usedw", 64'(usedw0), 64'd16);
    check("full_rw_drop", 64'(dc0), 64'd0);

    // empty queue, simultaneous read and write; underflow; flush with write
    step(0, 0, 1, '0);
    step(1, 1, 0, 32'hBEEF);
    check("empty_rw_q", 64'(q0), 64'hBEEF);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, $urandom);
    step(1, 0, 1, 32'h55);
    check("flush_usedw", 64'(usedw0), 64'd0);

    // randomized traffic with shifting bias
    for (int i = 0; i < 3000; i++) begin
      int wp;
      int rp;
      wp = ((i / 300) % 2 == 0) ? 75 : 35;
      rp = 100 - wp;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           $urandom_range(0, 199) == 0, $urandom);
    end

    // mid-operation asynchronous reset
    step(0, 0, 1, '0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, $urandom);
    #2 aclr = 1'b1;
    #1;
    check("midrst_rdempty", 64'(rdempty0), 64'd1);
    check("midrst_usedw", 64'(usedw0), 64'd0);
    check("midrst_drop", 64'(dc0), 64'd0);
    check("midrst_usedw_ovw", 64'(usedw1), 64'd0);
    m0.delete(); m1.delete(); md0 = 0; md1 = 0;
    @(negedge clk);
    aclr = 1'b0;
    step(1, 0, 0, 32'hA);
    check("midrst_readback", 64'(q0), 64'hA);
    step(0, 1, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
